// File: rtl/regfile_mp_if.sv
// Register-file bus: write ports, read ports and scoreboard set/busy signals.
// clk and rst stay outside the interface as plain ports of the block.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    logic [NWR-1:0]        we_i;
    logic [NWR*ADDR_W-1:0] waddr_i;
    logic [NWR*DATA_W-1:0] wdata_i;
    logic [NRD*ADDR_W-1:0] raddr_i;
    logic [NRD*DATA_W-1:0] rdata_o;
    logic [NRD-1:0]        busy_o;
    logic                  set_i;
    logic [ADDR_W-1:0]     set_addr_i;
    logic                  init_done_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, set_i, set_addr_i,
        input  rdata_o, busy_o, init_done_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, set_i, set_addr_i,
        output rdata_o, busy_o, init_done_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and a power-on clear sequence.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data/busy-clear to the read ports.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DEPTH-1:0]  r_busy;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_run;
    logic [ADDR_W-1:0] w_wa [NWR];
    logic [DATA_W-1:0] w_wd [NWR];
    logic [NWR-1:0]    w_wen;
    logic              w_set;
    logic [ADDR_W-1:0] w_ra [NRD];

    // Address 0 is filtered here so neither storage nor scoreboard ever sees it.
    always_comb begin
        w_run = (r_state == S_RUN);
        w_set = w_run && bus.set_i && (bus.set_addr_i != '0);
        for (int k = 0; k < NWR; k++) begin
            w_wa[k]  = bus.waddr_i[k*ADDR_W +: ADDR_W];
            w_wd[k]  = bus.wdata_i[k*DATA_W +: DATA_W];
            w_wen[k] = w_run && bus.we_i[k] && (w_wa[k] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
            r_cnt   <= ADDR_W'(1);
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + ADDR_W'(1);
            if (r_cnt == LAST)
                r_state <= S_RUN;
        end
    end

    // Clears first, then the set, so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (w_wen[k])
                    r_busy[w_wa[k]] <= 1'b0;
            if (w_set)
                r_busy[bus.set_addr_i] <= 1'b1;
        end
    end

    // Storage has no reset; later ports overwrite earlier ones on address collision.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (w_wen[k])
                    r_mem[w_wa[k]] <= w_wd[k];
        end
    end

    always_comb begin
        bus.rdata_o = '0;
        bus.busy_o  = '0;
        for (int j = 0; j < NRD; j++) begin
            w_ra[j] = bus.raddr_i[j*ADDR_W +: ADDR_W];
            if (w_run && (w_ra[j] != '0)) begin
                bus.rdata_o[j*DATA_W +: DATA_W] = r_mem[w_ra[j]];
                bus.busy_o[j]                   = r_busy[w_ra[j]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    if (w_wen[k] && (w_wa[k] == w_ra[j])) begin
                        bus.rdata_o[j*DATA_W +: DATA_W] = w_wd[k];
                        bus.busy_o[j] = w_set && (bus.set_addr_i == w_ra[j]);
                    end
                end
`endif
            end
        end
    end

    assign bus.init_done_o = w_run;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_nx = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) bus ();
    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic                         done;
        logic [NRD-1:0][DATA_W-1:0]   rd;
        logic [NRD-1:0]               bz;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int tests = 0;
    int fails = 0;

    // Reference state: register contents, busy flags, and cycles of clearing still to go.
    logic [DATA_W-1:0] m_mem  [DEPTH];
    logic              m_busy [DEPTH];
    int                init_left;

    function automatic void model_reset();
        init_left = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
        end
    endfunction

    // Apply the rules for one rising edge using the inputs held during the ending cycle.
    function automatic void model_edge();
        int wa, sa;
        if (!rst) begin
            model_reset();
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                wa = int'(bus.waddr_i[k*ADDR_W +: ADDR_W]);
                if (bus.we_i[k] && wa != 0) begin
                    m_mem[wa]  = bus.wdata_i[k*DATA_W +: DATA_W];
                    m_busy[wa] = 1'b0;
                end
            end
            sa = int'(bus.set_addr_i);
            if (bus.set_i && sa != 0)
                m_busy[sa] = 1'b1;
        end
    endfunction

    function automatic exp_t expect_now();
        exp_t x;
        int ra;
        x.done = rst && (init_left == 0);
        x.rd   = '0;
        x.bz   = '0;
        for (int j = 0; j < NRD; j++) begin
            ra = int'(bus.raddr_i[j*ADDR_W +: ADDR_W]);
            if (x.done && ra != 0) begin
                x.rd[j] = m_mem[ra];
                x.bz[j] = m_busy[ra];
`ifdef REGFILE_MP_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    if (bus.we_i[k] && int'(bus.waddr_i[k*ADDR_W +: ADDR_W]) == ra) begin
                        x.rd[j] = bus.wdata_i[k*DATA_W +: DATA_W];
                        x.bz[j] = bus.set_i && (int'(bus.set_addr_i) == ra);
                    end
                end
`endif
            end
        end
        return x;
    endfunction

    task automatic cyc(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic set, input logic [4:0] sa);
        @(posedge clk);
        #1;
        model_edge();
        rst = rst_nx;
        if (!rst) model_reset();
        bus.we_i       = we;
        bus.waddr_i    = {wa1, wa0};
        bus.wdata_i    = {wd1, wd0};
        bus.raddr_i    = {ra1, ra0};
        bus.set_i      = set;
        bus.set_addr_i = sa;
        q.push_back(expect_now());
    endtask

    task automatic rcyc(input int amax);
        cyc(2'($urandom), 5'($urandom_range(amax, 0)), $urandom,
            5'($urandom_range(amax, 0)), $urandom,
            5'($urandom_range(amax, 0)), 5'($urandom_range(amax, 0)),
            ($urandom_range(3, 0) == 0), 5'($urandom_range(amax, 0)));
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            if (bus.init_done_o !== e.done) begin
                fails++;
                $display("FAIL init_done t=%0t got %b exp %b", $time, bus.init_done_o, e.done);
            end
            for (int j = 0; j < NRD; j++) begin
                tests++;
                if (bus.rdata_o[j*DATA_W +: DATA_W] !== e.rd[j]) begin
                    fails++;
                    $display("FAIL rdata port%0d t=%0t addr %0d got %h exp %h", j, $time,
                             bus.raddr_i[j*ADDR_W +: ADDR_W], bus.rdata_o[j*DATA_W +: DATA_W], e.rd[j]);
                end
                tests++;
                if (bus.busy_o[j] !== e.bz[j]) begin
                    fails++;
                    $display("FAIL busy port%0d t=%0t addr %0d got %b exp %b", j, $time,
                             bus.raddr_i[j*ADDR_W +: ADDR_W], bus.busy_o[j], e.bz[j]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t queue %0d", $time, q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.we_i = '0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = '0;
        bus.set_i = 1'b0; bus.set_addr_i = '0;
        model_reset();

        // Held in reset, then the clear sequence with junk writes/sets and a full read sweep.
        rst_nx = 1'b0;
        repeat (3) rcyc(31);
        rst_nx = 1'b1;
        for (int i = 0; i < 34; i++)
            cyc(2'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom,
                5'(i % 32), 5'((i + 16) % 32), 1'b1, 5'($urandom));
        for (int i = 0; i < 16; i++)
            cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'(i), 5'(i + 16), 1'b0, 5'd0);

        // Same-address write collision: higher port wins.
        cyc(2'b11, 5'd5, 32'h11, 5'd5, 32'h22, 5'd5, 5'd1, 1'b0, 5'd0);
        cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0);

        // Read-during-write on address 7.
        cyc(2'b01, 5'd7, 32'h1234, 5'd0, 32'd0, 5'd7, 5'd6, 1'b0, 5'd0);
        cyc(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0);
        cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0);

        // Scoreboard on address 3: set, set+write, write alone.
        cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd3);
        cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd0);
        cyc(2'b01, 5'd3, 32'hA5, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1, 5'd3);
        cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd0);
        cyc(2'b10, 5'd0, 32'd0, 5'd3, 32'h5A, 5'd3, 5'd0, 1'b0, 5'd0);
        cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd0);

        // Address 0 ignores writes and sets.
        cyc(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
        cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);

        // Random traffic on a narrow address range to force collisions, then the full range.
        repeat (250) rcyc(7);
        repeat (100) rcyc(31);

        // Reset from RUN, then again in the middle of the clear sequence.
        rst_nx = 1'b0;
        repeat (2) rcyc(31);
        rst_nx = 1'b1;
        repeat (10) rcyc(31);
        rst_nx = 1'b0;
        repeat (2) rcyc(31);
        rst_nx = 1'b1;
        repeat (33) rcyc(31);
        for (int i = 0; i < 16; i++)
            cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'(i), 5'(i + 16), 1'b0, 5'd0);
        repeat (100) rcyc(7);

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain queue got %0d exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, giving the address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NRD, default 2, giving the number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, giving the number of write ports (1..2).
REQ-005 SHALL have the following ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- we_i  in  NWR  per-port write enable.
- waddr_i  in  NWR*ADDR_W  write addresses; port k at bits [k*ADDR_W +: ADDR_W].
- wdata_i  in  NWR*DATA_W  write data, packed the same way.
- raddr_i  in  NRD*ADDR_W  read addresses.
- rdata_o  out  NRD*DATA_W  read data, combinational.
- busy_o  out  NRD  scoreboard busy bit for each read address, combinational.
- set_i  in  1  marks register set_addr_i busy (an instruction issued with this destination).
- set_addr_i  in  ADDR_W  scoreboard set address.
- init_done_o  out  1  high once the storage clear sequence has finished.

Function
REQ-006 Register 0 SHALL always read as 0 and be never busy; writes and sets to address 0 SHALL be ignored.
REQ-007 The block SHALL have a two-state FSM, INIT and RUN; INIT is entered on reset.
REQ-008 In INIT, a clear counter SHALL start at 1 and write 0 to register[counter] each cycle, then increment.
REQ-009 The FSM SHALL go INIT->RUN in the cycle after the counter has cleared DEPTH-1; INIT therefore lasts DEPTH-1 cycles after reset deassertion.
REQ-010 init_done_o SHALL be 0 in INIT and 1 in RUN.
REQ-011 In INIT, we_i and set_i SHALL be ignored, and rdata_o and busy_o SHALL be all zeros.
REQ-012 In RUN, a write on port k with we_i[k]=1 and a nonzero address SHALL update the register on the next rising clk.
REQ-013 When two write ports target the same address in the same cycle, the higher port index SHALL win.
REQ-014 A write to address A SHALL clear busy[A] on the same edge.
REQ-015 set_i to address A SHALL set busy[A] on the next edge.
REQ-016 If a set and a clear hit the same address in the same cycle, the set SHALL win (busy[A]=1).
REQ-017 rdata_o and busy_o SHALL reflect current state combinationally, with zero-cycle latency from raddr_i.
REQ-018 Storage SHALL be plain flops or distributed RAM without reset; zeroing is done only by the INIT sequence.

Reset
REQ-019 On rst=0, regardless of clk, the FSM SHALL go to INIT, the clear counter to 1, all busy bits to 0 and init_done_o to 0.
REQ-020 Reset asserted in the middle of INIT or RUN SHALL restart the full clear sequence; no partial state is retained.

Configuration
REQ-021 Macro REGFILE_MP_BYPASS_EN SHALL control write-to-read bypass.
REQ-022 With REGFILE_MP_BYPASS_EN defined, a read of an address being written in the same RUN cycle SHALL return wdata of the highest-index matching write port, and busy_o for that address SHALL read 0 unless set_i targets the same address in that cycle.
REQ-023 Without REGFILE_MP_BYPASS_EN, reads SHALL return the stored value and the stored busy bit; the write becomes visible the cycle after.

Verification
REQ-024 Reset then read all addresses each cycle: init_done_o=0 for 31 cycles (DEPTH=32), then 1; every address reads 0 afterwards.
REQ-025 In RUN, write port 0 addr 5=0x11 and port 1 addr 5=0x22 in the same cycle: next cycle raddr 5 reads 0x22.
REQ-026 With bypass enabled, write addr 7=0xDEADBEEF while reading 7 in the same cycle: rdata=0xDEADBEEF; with bypass disabled, the old value is returned, and the new value the following cycle.
REQ-027 set_i addr 3, then busy for 3 reads 1; write addr 3 while set_i addr 3 in the same cycle: busy stays 1; a write alone then clears it to 0.
REQ-028 Write and set address 0 with 0xFFFFFFFF: reads 0, busy 0.
REQ-029 Assert rst at INIT cycle 10, release: init_done_o stays 0 for a further 31 cycles, and we_i and set_i are ignored throughout.
